fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
// - Downstream drain stage for the synchronous FIFO: pops one word whenever the FIFO is non-empty.
// - Serialises each word onto a UART-style line: start bit, DATA_W data bits LSB first, optional parity, stop bit(s).
// - Sole reader of the FIFO; connects to its rd/dout/empty ports.
// PARAMETERS
// - DATA_W        8   word width; must equal the FIFO data width
// - CLKS_PER_BIT  4   clk cycles per serial bit, >=2 (4 keeps simulations short)
// - STOP_BITS     1   number of stop bits, 1 or 2
// PORTS
// - clk         in   1       single system clock, rising edge
// - rst         in   1       synchronous reset, active-high
// - tx_en       in   1       1 = fetching allowed; 0 = finish the current frame, then hold in IDLE
// - fifo_empty  in   1       FIFO empty flag
// - fifo_dout   in   DATA_W  FIFO read data, registered in the FIFO and valid the cycle after fifo_rd
// - fifo_rd     out  1       FIFO read strobe, registered, one-cycle pulse per word
// - tx          out  1       serial line, registered, idles high
// - busy        out  1       high from REQ through the last STOP cycle
// - frame_done  out  1       one-cycle pulse on the cycle after the last stop-bit cycle
// BEHAVIOUR
// - Reset (synchronous, applied on the next edge): tx=1, fifo_rd=0, busy=0, frame_done=0, state=IDLE, counters=0.
// - FSM states and transitions:
//   - IDLE: if tx_en && !fifo_empty, go to REQ; otherwise stay.
//   - REQ: fifo_rd=1 for exactly this one cycle; go to LOAD.
//   - LOAD: capture fifo_dout into the shift register; go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles.
//   - DATA: send DATA_W bits LSB first, CLKS_PER_BIT cycles each.
//   - PARITY: present only with the macro (see CONFIGURATION).
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - After STOP: pulse frame_done and return to IDLE.
// - Counters: bit_cnt is $clog2(CLKS_PER_BIT) wide and wraps at CLKS_PER_BIT-1; idx counts 0..DATA_W-1.
// - Latency:
//   - tx falls 3 cycles after the first IDLE cycle that sees !fifo_empty (IDLE, REQ, LOAD).
//   - Frame length is (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity, else 0.
// - Back-to-back: the cycle after STOP is IDLE. If the FIFO is still non-empty, REQ follows.
//   - Inter-frame gap is therefore 3 cycles of tx=1.
// - fifo_rd is never asserted while fifo_empty=1; REQ is entered only from IDLE with !fifo_empty.
// - fifo_rd is never asserted more than once per frame.
// - tx_en deasserted mid-frame: the frame completes normally; no further REQ until tx_en=1.
// - Changes on fifo_empty outside IDLE are ignored.
// - fifo_dout is sampled only in LOAD.
// - Reset mid-frame: tx=1 on the next edge and the FSM returns to IDLE.
//   - The partially sent word is dropped and not re-read.
//   - frame_done is not pulsed.
// - Reset held during a pending REQ: fifo_rd=0, so no word is popped.
// CONFIGURATION
// - Macro FIFO_UART_TX_PARITY_EN.
//   - Defined: a PARITY state follows DATA. tx = XOR of all data bits (even parity) for CLKS_PER_BIT cycles.
//   - Undefined: DATA goes straight to STOP. No parity logic is synthesised.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, bench FIFO with registered dout)
// - Reset: rst=1 for 2 cycles -> tx=1, fifo_rd=0, busy=0, frame_done=0; with FIFO empty, no fifo_rd for 20 cycles.
// - Single word: push 0xA5 -> exactly one fifo_rd pulse.
//   - tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
//   - frame_done pulses once; busy=0 afterwards.
// - Back-to-back: push 0x01,0xFF,0x80 -> 3 fifo_rd pulses.
//   - Decoded bytes are 0x01,0xFF,0x80 in order.
//   - Exactly 3 idle-high cycles between frames; FIFO empty at the end.
// - tx_en gating: push 0x3C, 0xC3; drop tx_en during frame 1.
//   - 0x3C completes; no second fifo_rd while tx_en=0.
//   - Raising tx_en sends 0xC3.
// - Reset mid-frame: assert rst during DATA bit 3 of 0x55.
//   - tx=1 on the next edge; no frame_done.
//   - The next pushed word 0x0F is sent intact.
// - Parity (macro defined): 0xA5 -> parity bit 0, 44-cycle frame; 0x07 -> parity bit 1.

Source files
------------

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx : drains a synchronous FIFO, serialising each word as UART.
// Even parity bit is added when FIFO_UART_TX_PARITY_EN is defined.
// Revision: 1.0
// ============================================================================
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(DATA_W - 1);
  localparam logic          C_STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic [IW-1:0]     idx;
  logic              stop_idx;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par_bit;
`endif

  wire bit_end = (bit_cnt == C_BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      idx        <= '0;
      stop_idx   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_en && !fifo_empty) begin
            state   <= S_REQ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_REQ: state <= S_LOAD;
        // FIFO output is registered, so the popped word is valid here
        S_LOAD: begin
          shreg   <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
          par_bit <= ^fifo_dout;
`endif
          tx      <= 1'b0;
          bit_cnt <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            idx     <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (idx == C_IDX_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx       <= par_bit;
              state    <= S_PARITY;
`else
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= S_STOP;
`endif
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
              idx   <= idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_idx == C_STOP_LAST) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
